data_mem_param: RTL and testbench
=================================

# data_mem_param

Parametrised data memory for the single-cycle datapath, replacing the fixed 64×16 memory. Word width, depth and monitor-port width are set by parameters. Writes commit on the rising edge. A reset-driven clear sequencer zeroes every word after reset and raises `busy` while it runs. Out-of-range accesses are detected and reported through a sticky error flag instead of aliasing silently.

## Interface
- `DATA_W`, default 16: word width in bits.
- `ADDR_W`, default 8: width of the datapath address port.
- `DEPTH`, default 64: number of words, 2 ≤ DEPTH ≤ 2^ADDR_W.
- `MON_W`, default 4: width of the monitor address port.
- `CLEAR_ON_RST`, default 1: 1 = zero the whole array after reset; 0 = reset touches flags only.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `addr`, in, ADDR_W: read/write word address.
- `wdata`, in, DATA_W: write data.
- `w_en`, in, 1: write request for the current cycle.
- `rdata`, out, DATA_W: combinational read of `addr`.
- `monitor_addr`, in, MON_W: debug read address.
- `monitor_data`, out, DATA_W: combinational read of `monitor_addr`.
- `busy`, out, 1: clear sequence in progress; datapath accesses are blocked.
- `addr_err`, out, 1: sticky flag, set by any write with `addr` ≥ DEPTH.

## Operation
- States: CLEAR and READY.
  - `rst`=1: next state is CLEAR if CLEAR_ON_RST=1, else READY. Clear pointer ← 0. `addr_err` ← 0.
  - CLEAR with `rst`=0: write 0 to word[ptr], then ptr ← ptr+1. When ptr = DEPTH-1 is written, go to READY.
  - READY: hold until the next `rst`.
- `busy` is registered and equals (state == CLEAR).
  - Reset value: 1 if CLEAR_ON_RST, else 0.
- Datapath write: `w_en` & !`busy` & (`addr` < DEPTH) writes word[`addr`] ← `wdata` at the rising edge.
- Dropped writes:
  - `w_en` with `busy`=1 is dropped silently; `addr_err` is not set.
  - `w_en` with `addr` ≥ DEPTH while READY is dropped and sets `addr_err`.
  - `addr_err` stays set until `rst`.
- `rdata`:
  - word[`addr`] when READY and `addr` < DEPTH.
  - 0 when `busy`=1 or `addr` ≥ DEPTH.
- `monitor_data`:
  - word[`monitor_addr`] when `monitor_addr` < DEPTH.
  - 0 when out of range.
  - Never blocked by `busy`; it shows the words as they are cleared.
- With CLEAR_ON_RST=0, array contents persist across reset; only the state and `addr_err` reset.
- `rst` asserted mid-clear restarts the sequence at ptr 0.
- Addresses are compared zero-extended. No wrap-around: the array is never indexed with `addr` mod DEPTH.

## Timing
- Write latency: 1 edge. Data written at edge k is visible on `rdata`/`monitor_data` combinationally from edge k onward.
- Read latency: 0 cycles (combinational). Read-during-write to the same address returns old data before the edge and new data after it.
- Clear duration: `rst` is high through edge R and low from edge R+1.
  - Words 0..DEPTH-1 are cleared at edges R+1..R+DEPTH.
  - `busy` falls after edge R+DEPTH.
  - The first accepted datapath write is at edge R+DEPTH+1.
- CLEAR_ON_RST=0: `busy` is 0 from the first edge with `rst` high. A write is accepted at the first edge with `rst` low.
- Simultaneous `rst` and `w_en`: reset wins and the write is dropped.
- Clear write and datapath write never coincide, because `busy` gates the datapath.

## Structure
- Shared package `dm_pkg`:
  - state encoding constants `DM_CLEAR`, `DM_READY`;
  - default-width constants (16/8/64/4) reused by the datapath top.
- Sub-module `dm_array`:
  - parametrised DATA_W×DEPTH storage;
  - one write port (muxed between clear and datapath by the parent);
  - two combinational read ports.
- The FSM, pointer, range checks and flag logic stay in `data_mem_param`.

## Test plan
- Reset clear, defaults:
  - Stimulus: preload word 5 = 0x0004 with CLEAR_ON_RST=0 build, then switch to CLEAR_ON_RST=1, pulse `rst` 1 cycle.
  - Required: `busy`=1 for exactly 64 cycles; `rdata`=0 throughout; afterwards `monitor_addr`=5 gives 0x0000.
- Write/read:
  - Stimulus: after clear, write 0xFFFC to addr 10.
  - Required: `rdata`=0xFFFC from the edge onward; `monitor_addr`=10 gives 0xFFFC.
- Blocked write:
  - Stimulus: `w_en` with addr 3, data 0x1234, during `busy`.
  - Required: word 3 stays 0 and `addr_err`=0.
- Out of range:
  - Stimulus: write addr 64, data 0xBEEF, in READY.
  - Required: `addr_err`=1 and stays 1; `rdata`=0 for addr 64; words 0 and 63 unchanged.
  - Then pulse `rst`: `addr_err`=0.
- Mid-clear reset:
  - Stimulus: assert `rst` at clear cycle 20.
  - Required: the sequence restarts and `busy` lasts 64 further cycles after release.
- Parameter sweep:
  - Stimulus: DATA_W=32, DEPTH=256, ADDR_W=8; write 0xDEADBEEF at addr 255.
  - Required: readback matches; clear takes 256 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding and default geometry for the parametrised data memory.
`default_nettype none

package dm_pkg;

  typedef enum logic [0:0] {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  localparam int DM_DATA_W = 16;
  localparam int DM_ADDR_W = 8;
  localparam int DM_DEPTH  = 64;
  localparam int DM_MON_W  = 4;

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// dm_array: DATA_W x DEPTH storage with one synchronous write port and two combinational read ports.
`default_nettype none

module dm_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Indices past DEPTH-1 are masked by the parent before reaching any output.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/data_mem_param.sv
// data_mem_param: parametrised data memory with post-reset clear sequencer,
// busy gating and a sticky out-of-range write flag.
`default_nettype none

module data_mem_param
  import dm_pkg::*;
#(
  parameter int DATA_W       = DM_DATA_W,
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int DEPTH        = DM_DEPTH,
  parameter int MON_W        = DM_MON_W,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              w_en,
  output logic [DATA_W-1:0] rdata,
  input  logic [MON_W-1:0]  monitor_addr,
  output logic [DATA_W-1:0] monitor_data,
  output logic              busy,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MX_W  = (MON_W > IDX_W) ? MON_W : IDX_W;

  // One extra bit so DEPTH == 2^width still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [MX_W:0]    DEPTH_M = (MX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  dm_state_t         state;
  logic [IDX_W-1:0]  ptr;

  logic              addr_ok;
  logic              mon_ok;
  logic [MX_W-1:0]   mon_ext;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  mon_idx;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mon_word;

  assign addr_ok  = {1'b0, addr} < DEPTH_A;
  assign mon_ext  = MX_W'(monitor_addr);
  assign mon_ok   = {1'b0, mon_ext} < DEPTH_M;
  assign addr_idx = addr[IDX_W-1:0];
  assign mon_idx  = mon_ext[IDX_W-1:0];

  // Single write port: clear sequencer owns it while busy, datapath otherwise.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = addr_idx;
    wr_data = wdata;
    if (!rst) begin
      if (state == DM_CLEAR) begin
        wr_en   = 1'b1;
        wr_idx  = ptr;
        wr_data = '0;
      end else if (w_en && !busy && addr_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RST ? DM_CLEAR : DM_READY;
      busy     <= CLEAR_ON_RST;
      ptr      <= '0;
      addr_err <= 1'b0;
    end else begin
      if (w_en && !busy && !addr_ok) begin
        addr_err <= 1'b1;
      end
      if (state == DM_CLEAR) begin
        if (ptr == LAST) begin
          state <= DM_READY;
          busy  <= 1'b0;
        end else begin
          ptr <= ptr + IDX_W'(1);
        end
      end
    end
  end

  dm_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (wr_en),
    .waddr   (wr_idx),
    .wdata   (wr_data),
    .raddr_a (addr_idx),
    .rdata_a (rd_word),
    .raddr_b (mon_idx),
    .rdata_b (mon_word)
  );

  assign rdata        = (!busy && addr_ok) ? rd_word : '0;
  assign monitor_data = mon_ok ? mon_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_param.sv
// tb_data_mem_param: directed scoreboard bench over default, no-clear and wide builds.
`default_nettype none

module tb_data_mem_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build (clears on reset)
  logic        a_rst, a_w_en, a_busy, a_err;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata, a_rdata, a_mdata;
  logic [3:0]  a_maddr;

  // CLEAR_ON_RST = 0 build
  logic        b_rst, b_w_en, b_busy, b_err;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata, b_rdata, b_mdata;
  logic [3:0]  b_maddr;

  // Wide build: 32 x 256
  logic        c_rst, c_w_en, c_busy, c_err;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata, c_rdata, c_mdata;
  logic [7:0]  c_maddr;

  data_mem_param u_a (
    .clk(clk), .rst(a_rst), .addr(a_addr), .wdata(a_wdata), .w_en(a_w_en),
    .rdata(a_rdata), .monitor_addr(a_maddr), .monitor_data(a_mdata),
    .busy(a_busy), .addr_err(a_err)
  );

  data_mem_param #(.CLEAR_ON_RST(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .addr(b_addr), .wdata(b_wdata), .w_en(b_w_en),
    .rdata(b_rdata), .monitor_addr(b_maddr), .monitor_data(b_mdata),
    .busy(b_busy), .addr_err(b_err)
  );

  data_mem_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .MON_W(8)) u_c (
    .clk(clk), .rst(c_rst), .addr(c_addr), .wdata(c_wdata), .w_en(c_w_en),
    .rdata(c_rdata), .monitor_addr(c_maddr), .monitor_data(c_mdata),
    .busy(c_busy), .addr_err(c_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  // Counts observed busy cycles; on the default build also checks rdata is blocked.
  task automatic clear_count(input int sel, input int limit, output int n);
    n = 0;
    while (busy_of(sel) === 1'b1 && n < limit) begin
      if (sel == 0) begin
        push("clear_rdata_zero", 32'h0);
        check(32'(a_rdata));
      end
      step();
      n++;
    end
  endtask

  initial begin
    int n;

    a_rst = 1'b1; a_w_en = 1'b0; a_addr = '0; a_wdata = '0; a_maddr = '0;
    b_rst = 1'b1; b_w_en = 1'b0; b_addr = '0; b_wdata = '0; b_maddr = '0;
    c_rst = 1'b1; c_w_en = 1'b0; c_addr = '0; c_wdata = '0; c_maddr = '0;
    step();

    push("a_reset_busy", 32'h1);   check(32'(a_busy));
    push("a_reset_err", 32'h0);    check(32'(a_err));
    push("b_reset_busy", 32'h0);   check(32'(b_busy));
    push("b_reset_err", 32'h0);    check(32'(b_err));

    // First clear with a write request held throughout busy
    b_rst = 1'b0; c_rst = 1'b0;
    a_rst = 1'b0; a_w_en = 1'b1; a_addr = 8'd3; a_wdata = 16'h1234;
    #1;
    clear_count(0, 200, n);
    a_w_en = 1'b0;
    push("a_clear_len", 32'd64);   check(32'(n));
    a_maddr = 4'd3; #1;
    push("blocked_word3", 32'h0);  check(32'(a_mdata));
    push("blocked_err", 32'h0);    check(32'(a_err));

    // Preload word 5, reset, and confirm it is cleared
    a_addr = 8'd5; a_wdata = 16'h0004; a_w_en = 1'b1;
    step();
    a_w_en = 1'b0; a_maddr = 4'd5; #1;
    push("preload_word5", 32'h0004); check(32'(a_mdata));
    a_rst = 1'b1;
    step();
    a_rst = 1'b0; #1;
    clear_count(0, 200, n);
    push("reclear_len", 32'd64);   check(32'(n));
    a_maddr = 4'd5; #1;
    push("cleared_word5", 32'h0);  check(32'(a_mdata));

    // Write/read with read-during-write
    a_addr = 8'd10; a_wdata = 16'hFFFC; a_w_en = 1'b1; #1;
    push("rdw_old", 32'h0);        check(32'(a_rdata));
    step();
    a_w_en = 1'b0; #1;
    push("wr_rdata", 32'hFFFC);    check(32'(a_rdata));
    a_maddr = 4'd10; #1;
    push("wr_monitor", 32'hFFFC);  check(32'(a_mdata));

    // Out-of-range write
    a_addr = 8'd64; a_wdata = 16'hBEEF; a_w_en = 1'b1;
    step();
    a_w_en = 1'b0; #1;
    push("oor_err_set", 32'h1);    check(32'(a_err));
    push("oor_rdata", 32'h0);      check(32'(a_rdata));
    step(); step();
    push("oor_err_sticky", 32'h1); check(32'(a_err));
    a_addr = 8'd0; #1;
    push("oor_word0", 32'h0);      check(32'(a_rdata));
    a_addr = 8'd63; #1;
    push("oor_word63", 32'h0);     check(32'(a_rdata));

    // Reset with concurrent write, then mid-clear restart
    a_addr = 8'd12; a_wdata = 16'h5555; a_w_en = 1'b1; a_rst = 1'b1;
    step();
    a_rst = 1'b0; a_w_en = 1'b0; a_maddr = 4'd10; #1;
    push("rst_clears_err", 32'h0); check(32'(a_err));
    push("rst_busy", 32'h1);       check(32'(a_busy));
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        push("mon_before_clear", 32'hFFFC); check(32'(a_mdata));
      end
      if (k == 11) begin
        push("mon_after_clear", 32'h0);     check(32'(a_mdata));
      end
      step();
    end
    a_rst = 1'b1;
    step();
    a_rst = 1'b0; #1;
    clear_count(0, 200, n);
    push("midclear_len", 32'd64);  check(32'(n));

    // No-clear build: contents persist, reset wins over a write
    b_addr = 8'd5; b_wdata = 16'h0004; b_w_en = 1'b1;
    step();
    b_w_en = 1'b0; b_maddr = 4'd5; #1;
    push("b_write", 32'h0004);     check(32'(b_mdata));
    b_rst = 1'b1; b_wdata = 16'h7777; b_w_en = 1'b1;
    step();
    push("b_rst_busy", 32'h0);     check(32'(b_busy));
    push("b_rst_wins", 32'h0004);  check(32'(b_mdata));
    b_rst = 1'b0; b_wdata = 16'h0099;
    step();
    b_w_en = 1'b0; #1;
    push("b_first_write", 32'h0099); check(32'(b_mdata));
    b_addr = 8'd200; b_w_en = 1'b1;
    step();
    b_w_en = 1'b0; #1;
    push("b_oor_err", 32'h1);      check(32'(b_err));
    b_rst = 1'b1;
    step();
    b_rst = 1'b0; #1;
    push("b_err_cleared", 32'h0);  check(32'(b_err));
    push("b_persist", 32'h0099);   check(32'(b_mdata));

    // Wide build
    c_rst = 1'b1;
    step();
    c_rst = 1'b0; #1;
    clear_count(2, 600, n);
    push("c_clear_len", 32'd256);  check(32'(n));
    c_addr = 8'd255; c_wdata = 32'hDEADBEEF; c_w_en = 1'b1;
    step();
    c_w_en = 1'b0; c_maddr = 8'd255; #1;
    push("c_rdata", 32'hDEADBEEF); check(c_rdata);
    push("c_monitor", 32'hDEADBEEF); check(c_mdata);
    push("c_err", 32'h0);          check(32'(c_err));
    c_addr = 8'd0; #1;
    push("c_word0", 32'h0);        check(c_rdata);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
